// File: rtl/booth_divider.sv
// Signed 8-bit restoring divider, one step per clock; 9 cycles start-to-done, start ignored while busy.
// Optional DIV_ZERO_DETECT_EN short-circuits a zero divisor to a 1-cycle flagged result.
module booth_divider (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [7:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [7:0] remainder,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t     state;
   logic [7:0] q_reg;
   logic [7:0] m_reg;
   logic [8:0] a_reg;
   logic       sign_q;
   logic       sign_r;
   logic [3:0] cnt;

   logic [7:0] dvd_abs;
   logic [7:0] dvs_abs;
   logic [9:0] trial;

   // |-128| = 128 still fits in the unsigned 8-bit magnitude
   assign dvd_abs = dividend[7] ? (~dividend + 8'd1) : dividend;
   assign dvs_abs = divisor[7]  ? (~divisor  + 8'd1) : divisor;

   // Shifted partial remainder never exceeds 255, so bit 9 is a valid borrow/sign
   assign trial = {a_reg, q_reg[7]} - {2'b00, m_reg};

`ifdef DIV_ZERO_DETECT_EN
   logic dz_flag;
   logic dz_pend;
   assign div_by_zero = dz_flag;
`else
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         q_reg     <= 8'h00;
         m_reg     <= 8'h00;
         a_reg     <= 9'h000;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         cnt       <= 4'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= 8'h00;
         remainder <= 8'h00;
`ifdef DIV_ZERO_DETECT_EN
         dz_flag   <= 1'b0;
         dz_pend   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  q_reg  <= dvd_abs;
                  m_reg  <= dvs_abs;
                  a_reg  <= 9'h000;
                  sign_q <= dividend[7] ^ divisor[7];
                  sign_r <= dividend[7];
                  cnt    <= 4'd8;
                  busy   <= 1'b1;
                  state  <= CALC;
`ifdef DIV_ZERO_DETECT_EN
                  dz_flag <= 1'b0;
                  // Raw dividend is parked in q_reg to become the remainder
                  if (divisor == 8'h00) begin
                     q_reg   <= dividend;
                     busy    <= 1'b0;
                     dz_pend <= 1'b1;
                     state   <= DONE;
                  end
`endif
               end
            end

            CALC: begin
               if (trial[9]) begin
                  a_reg <= {a_reg[7:0], q_reg[7]};
                  q_reg <= {q_reg[6:0], 1'b0};
               end else begin
                  a_reg <= trial[8:0];
                  q_reg <= {q_reg[6:0], 1'b1};
               end
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= FIX;
               end
            end

            FIX: begin
               quotient  <= sign_q ? (~q_reg + 8'd1) : q_reg;
               remainder <= sign_r ? (~a_reg[7:0] + 8'd1) : a_reg[7:0];
               busy      <= 1'b0;
               done      <= 1'b1;
               state     <= DONE;
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
`ifdef DIV_ZERO_DETECT_EN
               if (dz_pend) begin
                  dz_pend   <= 1'b0;
                  dz_flag   <= 1'b1;
                  quotient  <= 8'h00;
                  remainder <= q_reg;
                  done      <= 1'b1;
                  state     <= DONE;
               end
`endif
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider.sv
// Directed, table-driven bench for booth_divider with hand-computed quotients and remainders.
module tb_booth_divider;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int compared = 0;
   int failed   = 0;
   int overlap  = 0;

   typedef struct {
      logic [7:0] dvd;
      logic [7:0] dvs;
      logic [7:0] q;
      logic [7:0] r;
   } vec_t;

   vec_t vecs [10];

   booth_divider dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic run_div(input logic [7:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] eq, input logic [7:0] er,
                          input int elat, input logic edz, input bit scramble,
                          input string tag);
      int  cyc;
      int  busy_cnt;
      bit  seen;
      @(negedge clk);
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      cyc      = 0;
      seen     = 1'b0;
      busy_cnt = busy ? 1 : 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (scramble && cyc == 3) begin
            dividend = 8'hFB;
            divisor  = 8'h01;
         end
         if (busy && done) overlap++;
         if (busy) busy_cnt++;
         if (done) seen = 1'b1;
      end
      check({tag, " latency"},   seen ? cyc : -1, elat);
      check({tag, " busy_cycles"}, busy_cnt, (elat == 9) ? 9 : 0);
      check({tag, " quotient"},  int'(quotient),  int'(eq));
      check({tag, " remainder"}, int'(remainder), int'(er));
      check({tag, " div_by_zero"}, int'(div_by_zero), int'(edz));
      @(posedge clk);
      #1;
      check({tag, " done_pulse"}, int'(done), 0);
   endtask

   initial begin
      int done_k;
      int rerise;
      bit prev_busy;
      bit seen;

      vecs[0] = '{8'd100, 8'd7,   8'h0E, 8'h02};
      vecs[1] = '{8'h9C,  8'd7,   8'hF2, 8'hFE};
      vecs[2] = '{8'd100, 8'hF9,  8'hF2, 8'h02};
      vecs[3] = '{8'h9C,  8'hF9,  8'h0E, 8'hFE};
      vecs[4] = '{8'd0,   8'd5,   8'h00, 8'h00};
      vecs[5] = '{8'h80,  8'hFF,  8'h80, 8'h00};
      vecs[6] = '{8'h80,  8'd1,   8'h80, 8'h00};
      vecs[7] = '{8'h7F,  8'h7F,  8'h01, 8'h00};
      vecs[8] = '{8'd5,   8'd9,   8'h00, 8'h05};
      vecs[9] = '{8'hFF,  8'd2,   8'h00, 8'hFF};

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = 8'h00;
      divisor  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy",        int'(busy), 0);
      check("reset done",        int'(done), 0);
      check("reset quotient",    int'(quotient), 0);
      check("reset remainder",   int'(remainder), 0);
      check("reset div_by_zero", int'(div_by_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_div(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, 9, 1'b0, 1'b0,
                 $sformatf("vec%0d", i));
      end

      // Operands disturbed during CALC must not affect the result
      run_div(8'd100, 8'd7, 8'h0E, 8'h02, 9, 1'b0, 1'b1, "scramble");

      // start held high: a single division, next acceptance 11 edges later
      @(negedge clk);
      dividend = 8'd20;
      divisor  = 8'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      done_k    = -1;
      rerise    = -1;
      prev_busy = busy;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         #1;
         if (busy && done) overlap++;
         if (done && done_k < 0) done_k = k;
         if (busy && !prev_busy && rerise < 0) rerise = k;
         prev_busy = busy;
      end
      start = 1'b0;
      check("held done_edge",   done_k, 9);
      check("held restart_edge", rerise, 11);
      check("held quotient",    int'(quotient), 6);
      check("held remainder",   int'(remainder), 2);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("held second_done", int'(seen), 1);

      // Results hold while idle with changing inputs
      dividend = 8'hAA;
      divisor  = 8'h03;
      repeat (5) @(posedge clk);
      #1;
      check("hold quotient",  int'(quotient), 6);
      check("hold remainder", int'(remainder), 2);

      // Reset during CALC step 4
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset busy",        int'(busy), 0);
      check("midreset done",        int'(done), 0);
      check("midreset quotient",    int'(quotient), 0);
      check("midreset remainder",   int'(remainder), 0);
      check("midreset div_by_zero", int'(div_by_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_div(8'd50, 8'd5, 8'h0A, 8'h00, 9, 1'b0, 1'b0, "post_reset");

`ifdef DIV_ZERO_DETECT_EN
      run_div(8'd37, 8'd0, 8'h00, 8'd37, 1, 1'b1, 1'b0, "zero_div");
      run_div(8'd9, 8'd3, 8'h03, 8'h00, 9, 1'b0, 1'b0, "dz_cleared");
`else
      run_div(8'd37, 8'd0, 8'hFF, 8'd37, 9, 1'b0, 1'b0, "zero_div");
      run_div(8'hDB, 8'd0, 8'h01, 8'hDB, 9, 1'b0, 1'b0, "zero_div_neg");
`endif

      check("busy_done_overlap", overlap, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
